// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: one shared frame counter, per-channel duty compare.
// Period/duty are shadowed and applied at frame boundaries, with optional slew.
module servo_pwm_multi #(
  parameter int NCH            = 6,
  parameter int CW             = 32,
  parameter int SELW           = 3,
  parameter int DEFAULT_PERIOD = 1000000,
  parameter int DEFAULT_DUTY   = 75000,
  parameter int STEP           = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            period_wr,
  input  logic [CW-1:0]   period_in,
  input  logic            wr_en,
  input  logic [SELW-1:0] wr_sel,
  input  logic [CW-1:0]   wr_duty,
  output logic [NCH-1:0]  pwm,
  output logic            frame_start,
  output logic [NCH-1:0]  busy
);

  localparam logic [CW-1:0] DEF_P = CW'(DEFAULT_PERIOD);
  localparam logic [CW-1:0] DEF_D = CW'(DEFAULT_DUTY);
  localparam logic [CW-1:0] STP   = CW'(STEP);
  localparam logic [CW-1:0] MIN_P = CW'(2);

  logic [CW-1:0]           cnt;
  logic                    running;
  logic [CW-1:0]           period_shadow;
  logic [CW-1:0]           period_act;
  logic [NCH-1:0][CW-1:0]  target;
  logic [NCH-1:0][CW-1:0]  duty_act;

  logic                    bnd;
  logic [CW-1:0]           cnt_nxt;
  logic [CW-1:0]           ps_nxt;
  logic [CW-1:0]           pa_nxt;
  logic [NCH-1:0][CW-1:0]  tgt_nxt;
  logic [NCH-1:0][CW-1:0]  duty_nxt;
  logic [NCH-1:0]          pwm_nxt;
  logic [NCH-1:0]          busy_nxt;

  // Slew step toward target; compares before subtracting so no underflow.
  function automatic logic [CW-1:0] slew(
    input logic [CW-1:0] cur,
    input logic [CW-1:0] tgt
  );
    logic [CW-1:0] r;
    r = tgt;
    if (STEP != 0) begin
      if (tgt > cur) begin
        if (tgt - cur > STP) r = cur + STP;
      end else if (cur > tgt) begin
        if (cur - tgt > STP) r = cur - STP;
      end
    end
    return r;
  endfunction

  // Next-state: boundary detect, shadow writes, slew and output compare.
  always_comb begin
    bnd      = enable && (!running || cnt == period_act - CW'(1));
    cnt_nxt  = '0;
    ps_nxt   = period_shadow;
    pa_nxt   = period_act;
    tgt_nxt  = target;
    duty_nxt = duty_act;
    pwm_nxt  = '0;
    busy_nxt = '0;
    if (period_wr)
      ps_nxt = (period_in < MIN_P) ? MIN_P : period_in;
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && wr_sel == SELW'(i))
        tgt_nxt[i] = wr_duty;
    end
    if (enable) begin
      if (bnd) begin
        cnt_nxt = '0;
        pa_nxt  = period_shadow;
        for (int i = 0; i < NCH; i++)
          duty_nxt[i] = slew(duty_act[i], target[i]);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      for (int i = 0; i < NCH; i++)
        pwm_nxt[i] = cnt_nxt < duty_nxt[i];
    end
    for (int i = 0; i < NCH; i++)
      busy_nxt[i] = duty_nxt[i] != tgt_nxt[i];
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      running       <= 1'b0;
      period_shadow <= DEF_P;
      period_act    <= DEF_P;
      for (int i = 0; i < NCH; i++) begin
        target[i]   <= DEF_D;
        duty_act[i] <= DEF_D;
      end
      pwm           <= '0;
      frame_start   <= 1'b0;
      busy          <= '0;
    end else begin
      cnt           <= cnt_nxt;
      running       <= enable;
      period_shadow <= ps_nxt;
      period_act    <= pa_nxt;
      target        <= tgt_nxt;
      duty_act      <= duty_nxt;
      pwm           <= pwm_nxt;
      frame_start   <= enable && (cnt_nxt == '0);
      busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (no slew, slew=2) against a
// frame-level reference model; directed scenarios then random traffic.
module tb_servo_pwm_multi;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DP  = 10;
  localparam int DD  = 3;

  logic            clk = 0;
  logic            reset;
  logic            enable;
  logic            period_wr;
  logic [CW-1:0]   period_in;
  logic            wr_en;
  logic [2:0]      wr_sel;
  logic [CW-1:0]   wr_duty;
  logic [NCH-1:0]  pwm_a, pwm_b, busy_a, busy_b;
  logic            fs_a, fs_b;

  int vectors = 0;
  int miscompares = 0;

  servo_pwm_multi #(.NCH(NCH), .CW(CW), .SELW(3), .DEFAULT_PERIOD(DP),
    .DEFAULT_DUTY(DD), .STEP(0)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .period_wr(period_wr),
    .period_in(period_in), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_duty(wr_duty), .pwm(pwm_a), .frame_start(fs_a), .busy(busy_a));

  servo_pwm_multi #(.NCH(NCH), .CW(CW), .SELW(3), .DEFAULT_PERIOD(DP),
    .DEFAULT_DUTY(DD), .STEP(2)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .period_wr(period_wr),
    .period_in(period_in), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_duty(wr_duty), .pwm(pwm_b), .frame_start(fs_b), .busy(busy_b));

  always #5 clk = ~clk;

  // Reference: frame position, pending/active period, per-channel duties.
  int  m_pos;
  bit  m_live;
  int  m_pend_p, m_act_p;
  int  m_tgt[2][NCH];
  int  m_duty[2][NCH];
  int  steps[2] = '{0, 2};
  logic [NCH-1:0] e_pwm[2], e_busy[2];
  logic e_fs;

  function automatic int approach(int cur, int tgt, int st);
    if (st == 0) return tgt;
    if (tgt > cur) return (tgt - cur <= st) ? tgt : cur + st;
    return (cur - tgt <= st) ? tgt : cur - st;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pos = 0; m_live = 0; m_pend_p = DP; m_act_p = DP;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++) begin
          m_tgt[k][c] = DD; m_duty[k][c] = DD;
        end
      e_fs = 0; e_pwm = '{default: '0}; e_busy = '{default: '0};
      return;
    end
    if (enable) begin
      if (!m_live || m_pos == m_act_p - 1) begin
        m_pos = 0;
        m_act_p = m_pend_p;
        for (int k = 0; k < 2; k++)
          for (int c = 0; c < NCH; c++)
            m_duty[k][c] = approach(m_duty[k][c], m_tgt[k][c], steps[k]);
      end else begin
        m_pos++;
      end
      m_live = 1;
      e_fs = (m_pos == 0);
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++)
          e_pwm[k][c] = m_pos < m_duty[k][c];
    end else begin
      m_pos = 0; m_live = 0; e_fs = 0; e_pwm = '{default: '0};
    end
    if (period_wr) m_pend_p = (period_in < 2) ? 2 : int'(period_in);
    if (wr_en && wr_sel < NCH)
      for (int k = 0; k < 2; k++) m_tgt[k][wr_sel] = int'(wr_duty);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++)
        e_busy[k][c] = m_duty[k][c] != m_tgt[k][c];
  endtask

  task automatic check();
    vectors++;
    assert (pwm_a === e_pwm[0]) else begin
      miscompares++;
      $error("FAIL pwm_a got %b exp %b t=%0t", pwm_a, e_pwm[0], $time);
    end
    vectors++;
    assert (pwm_b === e_pwm[1]) else begin
      miscompares++;
      $error("FAIL pwm_b got %b exp %b t=%0t", pwm_b, e_pwm[1], $time);
    end
    vectors++;
    assert (fs_a === e_fs && fs_b === e_fs) else begin
      miscompares++;
      $error("FAIL frame_start got %b/%b exp %b t=%0t", fs_a, fs_b, e_fs,
             $time);
    end
    vectors++;
    assert (busy_a === e_busy[0]) else begin
      miscompares++;
      $error("FAIL busy_a got %b exp %b t=%0t", busy_a, e_busy[0], $time);
    end
    vectors++;
    assert (busy_b === e_busy[1]) else begin
      miscompares++;
      $error("FAIL busy_b got %b exp %b t=%0t", busy_b, e_busy[1], $time);
    end
  endtask

  // One clock: model sees the same inputs as the DUT, check mid-cycle.
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check();
      wr_en = 0;
      period_wr = 0;
    end
  endtask

  task automatic wr(int ch, int d);
    wr_en = 1; wr_sel = 3'(ch); wr_duty = CW'(d);
  endtask

  task automatic pwr(int p);
    period_wr = 1; period_in = CW'(p);
  endtask

  int pw;

  initial begin
    reset = 1; enable = 0; period_wr = 0; period_in = '0;
    wr_en = 0; wr_sel = '0; wr_duty = '0;
    @(negedge clk);
    cyc(2);
    reset = 0;
    cyc(1);
    // duties 3 / 0 / 12, run several frames
    wr(1, 0); cyc(1);
    wr(2, 12); cyc(1);
    enable = 1;
    cyc(25);
    // mid-frame duty change on ch0
    wr(0, 7); cyc(1);
    cyc(15);
    // period change mid-frame, then a write on a boundary cycle
    pwr(6); cyc(3);
    while (!(u_a.cnt == CW'(DP - 1))) cyc(1);
    wr(0, 2); cyc(1);
    cyc(20);
    // slew from 0 to 7 on ch1; count ch1 pulse width in the slewed DUT
    wr(1, 7); cyc(1);
    pw = 0;
    repeat (30) begin
      cyc(1);
      if (pwm_b[1]) pw++;
    end
    vectors++;
    assert (pw > 0 && busy_b[1] === 1'b0) else begin
      miscompares++;
      $error("FAIL slew_settle got pw=%0d busy=%b exp busy 0", pw,
             busy_b[1]);
    end
    // enable drop mid-frame and restart
    pwr(10); cyc(8);
    enable = 0; cyc(3);
    enable = 1; cyc(14);
    // reset mid-frame with changed targets, then out-of-range select
    wr(0, 9); cyc(2);
    reset = 1; cyc(1);
    reset = 0; cyc(1);
    wr(7, 1); cyc(1);
    cyc(22);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ($urandom_range(0, 99) < 8) pwr($urandom_range(0, 12));
      if ($urandom_range(0, 99) < 20)
        wr($urandom_range(0, 7), $urandom_range(0, 14));
      if ($urandom_range(0, 999) < 3) reset = 1;
      cyc(1);
      reset = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel servo PWM generator: one shared frame counter drives NCH independent duty comparators. Duty and period are written into shadow registers and take effect only at frame boundaries, so there are no glitched or runt pulses. An optional per-channel slew limiter ramps the active duty toward its target in bounded steps per frame. The block sits between the cube-solver move sequencer (register writes) and the servo output pins.

Parameters:
NCH, 6, number of servo channels (1..16)
CW, 32, width of counter, period and duty values
SELW, 3, width of channel select; must satisfy 2^SELW >= NCH
DEFAULT_PERIOD, 1000000, reset frame length in clk cycles (20 ms at 50 MHz)
DEFAULT_DUTY, 75000, reset duty for every channel (1.5 ms, servo centre)
STEP, 0, max duty change per frame per channel; 0 = no slew limit (jump directly)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  run frames; low = idle, outputs low
period_wr  in  1  load period_in into period shadow
period_in  in  CW  requested frame length in cycles
wr_en  in  1  load wr_duty into target of channel wr_sel
wr_sel  in  SELW  channel index
wr_duty  in  CW  requested high time in cycles
pwm  out  NCH  servo outputs, registered
frame_start  out  1  one-cycle pulse marking the first cycle of each frame
busy  out  NCH  bit i high while the active duty of channel i differs from its target

Behaviour:
- Reset (sync, takes priority over everything): cnt=0, running=0, pwm=0, frame_start=0, busy=0; period_shadow=period_act=DEFAULT_PERIOD; target[i]=duty_act[i]=DEFAULT_DUTY.
- Period clamp: a period_in below 2 is stored as 2.
- Writes: wr_en with wr_sel<NCH sets target[wr_sel]; wr_sel>=NCH is ignored. Writes are accepted whether or not enable is high. Two writes to one channel before a boundary: last wins.
- Boundary event B fires when (enable && !running) or (enable && cnt==period_act-1). On B:
  - cnt<=0, running<=1, period_act<=period_shadow.
  - For each i: if STEP==0 or |target-duty_act|<=STEP, duty_act<=target; else duty_act moves toward target by exactly STEP.
  - B samples target and period_shadow as they were before any write in the same cycle; a same-cycle write applies at the next boundary.
- Otherwise, when enable is high: cnt<=cnt+1.
- enable low: cnt<=0, running<=0, pwm<=0, frame_start<=0; duty_act and period_act are frozen. Dropping enable mid-frame truncates that frame. Re-enable starts a fresh frame through B on the first enabled cycle.
- Outputs are registered from the counter value of the current cycle (one-cycle latency):
  - frame_start <= enable && (next cnt == 0).
  - pwm[i] <= enable && (next cnt < duty_act_next[i]).
  - pwm[i] is therefore high for exactly min(duty_act, period_act) cycles, starting in the frame_start cycle.
- Duty edge cases: duty_act==0 gives a constant low frame. duty_act>=period_act gives a constant high frame with no gap between frames.
- busy[i] = (duty_act[i] != target[i]), registered.
- All arithmetic is unsigned CW-bit. The slew subtraction compares before it subtracts, so it never underflows.

Test Plan:
- NCH=3, STEP=0, period=10, duties 3/0/12, enable held high -> frame_start every 10 cycles; pwm0 high 3 cycles per frame; pwm1 always 0; pwm2 always 1.
- Mid-frame write of ch0 duty 3->7 at cnt=4 -> current frame keeps a 3-cycle pulse; the next frame has a 7-cycle pulse; no runt pulse.
- period_wr of 6 mid-frame, then a write on the exact boundary cycle -> current frame completes 10 cycles; the next frame is 6; the boundary-cycle duty write appears one frame later.
- STEP=2, ch1 target 0->7 -> pulse widths per frame 2, 4, 6, 7; busy1 high until the frame showing 7, low after.
- enable dropped at cnt=5, raised 3 cycles later -> pwm goes 0 the cycle after enable drops; on re-enable, frame_start pulses and a full 10-cycle frame runs.
- reset asserted mid-frame with modified targets -> next cycle all outputs 0; after release, duties and period return to their defaults; wr_sel=7 write (NCH=3) has no effect.
